// File: rtl/addr_sequencer.sv
// addr_sequencer: strided address sweep over [base, limit] with consumer handshake, wrap/one-shot modes.
// Define ADDR_SEQ_DOWN_EN to add the cfg_down input for descending sweeps from limit to base.
module addr_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int STRIDE_W = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_limit,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic                cfg_wrap,
`ifdef ADDR_SEQ_DOWN_EN
    input  logic                cfg_down,
`endif
    input  logic                rdy,
    output logic [ADDR_W-1:0]   address,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic                wrap_pulse,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    pass_count
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] base_q, limit_q, base_n, limit_n, addr_n, reload;
    logic [STRIDE_W-1:0] stride_q, stride_n;
    logic [CNT_W-1:0] cnt_n;
    logic [ADDR_W:0] step, sum;
    logic wrap_q, wrap_n, wp_n, err_n, last;
`ifdef ADDR_SEQ_DOWN_EN
    logic down_q, down_n;
`endif
    assign valid = state == RUN;
    assign busy  = state == RUN;
    assign done  = state == FIN;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            address    <= '0;
            base_q     <= '0;
            limit_q    <= '0;
            stride_q   <= STRIDE_W'(1);
            wrap_q     <= 1'b0;
            wrap_pulse <= 1'b0;
            cfg_err    <= 1'b0;
            pass_count <= '0;
`ifdef ADDR_SEQ_DOWN_EN
            down_q     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            address    <= addr_n;
            base_q     <= base_n;
            limit_q    <= limit_n;
            stride_q   <= stride_n;
            wrap_q     <= wrap_n;
            wrap_pulse <= wp_n;
            cfg_err    <= err_n;
            pass_count <= cnt_n;
`ifdef ADDR_SEQ_DOWN_EN
            down_q     <= down_n;
`endif
        end
    end
    // Next address is formed one bit wider so a carry/borrow ends the pass instead of wrapping.
    always_comb begin
        step = (ADDR_W+1)'(stride_q);
`ifdef ADDR_SEQ_DOWN_EN
        sum    = down_q ? {1'b0, address} - step : {1'b0, address} + step;
        last   = down_q ? (sum[ADDR_W] || sum[ADDR_W-1:0] < base_q) : sum > {1'b0, limit_q};
        reload = down_q ? limit_q : base_q;
        down_n = down_q;
`else
        sum    = {1'b0, address} + step;
        last   = sum > {1'b0, limit_q};
        reload = base_q;
`endif
        state_n  = state;
        addr_n   = address;
        base_n   = base_q;
        limit_n  = limit_q;
        stride_n = stride_q;
        wrap_n   = wrap_q;
        cnt_n    = pass_count;
        wp_n     = 1'b0;
        err_n    = 1'b0;
        if (state == IDLE && start) begin
            if (cfg_base > cfg_limit) begin
                err_n = 1'b1;
            end else begin
                state_n  = RUN;
                base_n   = cfg_base;
                limit_n  = cfg_limit;
                stride_n = cfg_stride == '0 ? STRIDE_W'(1) : cfg_stride;
                wrap_n   = cfg_wrap;
                cnt_n    = '0;
`ifdef ADDR_SEQ_DOWN_EN
                down_n   = cfg_down;
                addr_n   = cfg_down ? cfg_limit : cfg_base;
`else
                addr_n   = cfg_base;
`endif
            end
        end else if (state == RUN && stop) begin
            state_n = IDLE;
        end else if (state == RUN && rdy) begin
            if (!last) begin
                addr_n = sum[ADDR_W-1:0];
            end else begin
                cnt_n = &pass_count ? pass_count : pass_count + CNT_W'(1);
                if (wrap_q) begin
                    addr_n = reload;
                    wp_n   = 1'b1;
                end else begin
                    state_n = FIN;
                end
            end
        end else if (state == FIN) begin
            state_n = IDLE;
        end
    end
endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Parametrised memory address generator that sweeps a programmable window [base, limit] with a programmable stride.
- Drives the address bus of the on-chip data memory for vector load/store and encryption passes.
- Handshakes each address with the consumer and supports wrap (continuous) or one-shot modes.
- Reports pass completion and pass count to the control unit.

Parameters:
- ADDR_W, 16, address width in bits.
- STRIDE_W, 8, width of stride input.
- CNT_W, 8, width of pass counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled in IDLE only.
- stop  in  1  synchronous abort.
- cfg_base  in  ADDR_W  first address of window.
- cfg_limit  in  ADDR_W  last address of window, inclusive.
- cfg_stride  in  STRIDE_W  increment per beat; 0 treated as 1.
- cfg_wrap  in  1  1 = wrap continuously, 0 = one-shot.
- rdy  in  1  consumer accepts current address.
- address  out  ADDR_W  current address.
- valid  out  1  address is valid.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse at end of a one-shot pass.
- wrap_pulse  out  1  one-cycle pulse when a wrap occurs.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- pass_count  out  CNT_W  number of completed passes; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; address=0; valid=busy=done=wrap_pulse=cfg_err=0; pass_count=0. Latched config is cleared to base=0, limit=0, stride=1, wrap=0.
- States: IDLE, RUN, FIN.
- IDLE, start=1, cfg_base<=cfg_limit:
  - Latch base, limit, stride and wrap.
  - Next cycle: address=base, valid=1, busy=1, state=RUN, pass_count=0.
- IDLE, start=1, cfg_base>cfg_limit: stay in IDLE; cfg_err=1 for one cycle; outputs otherwise unchanged.
- start is ignored in RUN and FIN. cfg_* inputs are only sampled at accepted start.
- RUN beat: a beat is valid&rdy. While rdy=0, address and valid hold stable.
- Next-address rule, computed in ADDR_W+1 bits: sum = address + stride.
  - sum <= limit: address=sum.
  - sum > limit (end of pass), wrap=1: address=base; wrap_pulse=1 for one cycle; pass_count increments (saturating). Stay in RUN.
  - sum > limit, wrap=0: valid=0, busy=0, done=1 for one cycle; pass_count increments; state=FIN. address holds the last beat's value.
- FIN: unconditionally returns to IDLE next cycle.
- The limit address is issued only if it is reachable from base by the stride. Carry out of ADDR_W never wraps the address silently.
- stop=1 in RUN, with priority over a simultaneous beat: next cycle state=IDLE, valid=0, busy=0, address holds. No done, no pass_count change.
- stop in IDLE or FIN has no effect.
- Reset asserted mid-RUN returns to the reset values immediately.
- Latency: start to first valid is 1 cycle. Each beat to next address is 1 cycle. Full rate is possible with rdy held at 1.
- Legacy equivalence: base=0, limit=35000, stride=1, wrap=1, rdy=1 gives the free-running 0..35000 sweep.

Optional Feature:
- ADDR_SEQ_DOWN_EN defined:
  - Adds input cfg_down (1 bit), latched at start.
  - When cfg_down=1, the first address is limit. Each beat computes diff = address - stride with borrow.
  - End of pass occurs when diff < base or a borrow occurs. On wrap, address reloads limit. done and wrap_pulse behave as in up mode.
- ADDR_SEQ_DOWN_EN undefined: cfg_down does not exist; up-counting only.

Test Plan:
- Reset: assert reset=0 mid-RUN at address=0x0010 -> address=0, valid=0, pass_count=0 the same cycle.
- One-shot: base=0x0100, limit=0x0105, stride=2, wrap=0, rdy=1.
  - Addresses 0x100, 0x102, 0x104.
  - done pulses the cycle after the 0x104 beat; valid=0; pass_count=1.
- Wrap with backpressure: base=0, limit=3, stride=1, wrap=1, rdy toggling 1,0.
  - Sequence 0,1,2,3,0,1 with each address held while rdy=0.
  - wrap_pulse once per 3->0; pass_count=2 after 8 beats.
- Top of range: base=0xFFF0, limit=0xFFFF, stride=8, wrap=0.
  - Addresses 0xFFF0, 0xFFF8, then done.
  - No carry into address 0x0000.
- Abort and errors:
  - stop asserted together with a beat at address 5 -> IDLE, valid=0, address=5, done=0.
  - Start with base=10, limit=4 -> cfg_err pulse, state stays IDLE.
- Stride 0: stride=0, base=7, limit=9 -> 7,8,9 (treated as 1).
- Down mode (only with ADDR_SEQ_DOWN_EN): base=2, limit=8, stride=3, cfg_down=1, wrap=0 -> addresses 8, 5, 2, then done.
